// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use hazard unit.
// Tracks the EX instruction plus DEPTH post-EX stages, picks the nearest
// forwarding source for each EX operand and stalls ID while a needed load
// result is still too young to forward.
module forward_hazard_unit #(
  parameter int unsigned AW       = 5,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned NULL_REG = 31
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                hold,
  input  logic                                flush,
  input  logic                                id_valid,
  input  logic [NSRC*AW-1:0]                  id_src,
  input  logic [AW-1:0]                       id_dst,
  input  logic                                id_regwrite,
  input  logic                                id_is_load,
  output logic                                stall,
  output logic [NSRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
  output logic                                ex_valid,
  output logic [15:0]                         stall_cnt
);

  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] NULL_A = AW'(NULL_REG);

  // Tracker: index 0 = EX, index k = post-EX stage k.
  logic            vld    [DEPTH+1];
  logic            wr     [DEPTH+1];
  logic [AW-1:0]   dst    [DEPTH+1];
  // Load flag only matters for stall detection, which looks at 0..DEPTH-1.
  logic            ld     [DEPTH];
  logic [NSRC*AW-1:0] ex_src;

  logic [DEPTH:0]  qw;

  // Qualified writer flags per tracker entry.
  always_comb begin
    qw = '0;
    for (int k = 0; k <= int'(DEPTH); k++) begin
      qw[k] = vld[k] && wr[k] && (dst[k] != NULL_A);
    end
  end

  // Nearest-stage forwarding select for each EX operand.
  always_comb begin
    logic [AW-1:0] f_src;
    logic [SW-1:0] f_sel;
    logic          f_found;
    fwd_sel = '0;
    f_src   = '0;
    f_sel   = '0;
    f_found = 1'b0;
    for (int s = 0; s < int'(NSRC); s++) begin
      f_src   = ex_src[s*AW +: AW];
      f_sel   = '0;
      f_found = 1'b0;
      for (int k = 1; k <= int'(DEPTH); k++) begin
        if (!f_found && qw[k] && (dst[k] == f_src)) begin
          f_sel   = SW'(k);
          f_found = 1'b1;
        end
      end
      if (!vld[0] || (f_src == NULL_A)) f_sel = '0;
      fwd_sel[s*SW +: SW] = f_sel;
    end
  end

  // Load-use stall: nearest matching writer is a load not yet forwardable.
  always_comb begin
    logic [AW-1:0] h_src;
    logic          h_found;
    stall   = 1'b0;
    h_src   = '0;
    h_found = 1'b0;
    for (int s = 0; s < int'(NSRC); s++) begin
      h_src   = id_src[s*AW +: AW];
      h_found = 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (!h_found && qw[j] && (dst[j] == h_src)) begin
          h_found = 1'b1;
          if (ld[j] && ((j + 1) < int'(LOAD_LAT)) && id_valid && (h_src != NULL_A)) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  assign ex_valid = vld[0];

  // Tracker shift, EX entry load/bubble, and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= int'(DEPTH); k++) begin
        vld[k] <= 1'b0;
        wr[k]  <= 1'b0;
        dst[k] <= '0;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
        ld[k] <= 1'b0;
      end
      ex_src    <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        vld[k] <= vld[k-1];
        wr[k]  <= wr[k-1];
        dst[k] <= dst[k-1];
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        ld[k] <= ld[k-1];
      end
      if (!flush && id_valid && !stall) begin
        vld[0] <= 1'b1;
        wr[0]  <= id_regwrite;
        ld[0]  <= id_is_load;
        dst[0] <= id_dst;
        ex_src <= id_src;
      end else begin
        vld[0] <= 1'b0;
        wr[0]  <= 1'b0;
        ld[0]  <= 1'b0;
      end
      if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit at default parameters.
module tb_forward_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [2*AW-1:0]   id_src;
  logic [AW-1:0]     id_dst;
  logic              id_regwrite;
  logic              id_is_load;
  logic              stall;
  logic [2*SW-1:0]   fwd_sel;
  logic              ex_valid;
  logic [15:0]       stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  forward_hazard_unit dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .stall(stall), .fwd_sel(fwd_sel), .ex_valid(ex_valid),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [AW-1:0] d, input logic rw, input logic lo);
    id_valid    = v;
    id_src      = {s1, s0};
    id_dst      = d;
    id_regwrite = rw;
    id_is_load  = lo;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_exv", 32'(ex_valid), 32'd0);
    chk("rst_fwd", 32'(fwd_sel), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    #10 rst = 1'b0;
    tick();

    // ALU write r3 then immediate reader
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 5'd10, 1'b0, 1'b0);
    chk("alu_nostall", 32'(stall), 32'd0);
    tick();
    chk("alu_fwd1", 32'(fwd_sel), 32'h1);
    chk("alu_exv", 32'(ex_valid), 32'd1);
    idle();

    // ALU write r3, bubble, reader -> stage 2
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 5'd10, 1'b0, 1'b0);
    tick();
    chk("gap_fwd2", 32'(fwd_sel), 32'h2);
    idle();

    // Two writers of r3 back to back: nearest wins
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 5'd10, 1'b0, 1'b0);
    tick();
    chk("near_fwd1", 32'(fwd_sel), 32'h1);
    idle();

    // Load r4, reader in src1: one stall cycle
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    chk("ld_nostall_pre", 32'(stall), 32'd0);
    tick();
    set_id(1'b1, 5'd0, 5'd4, 5'd10, 1'b0, 1'b0);
    chk("ld_stall", 32'(stall), 32'd1);
    tick();
    chk("ld_stall_end", 32'(stall), 32'd0);
    chk("ld_bubble", 32'(ex_valid), 32'd0);
    chk("ld_cnt1", 32'(stall_cnt), 32'd1);
    tick();
    chk("ld_fwd_s1", 32'(fwd_sel), 32'h8);
    chk("ld_exv", 32'(ex_valid), 32'd1);
    chk("ld_cnt_hold", 32'(stall_cnt), 32'd1);
    idle();

    // NULL register never forwards or stalls
    set_id(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd31, 5'd31, 5'd10, 1'b0, 1'b0);
    chk("null_nostall", 32'(stall), 32'd0);
    tick();
    chk("null_fwd", 32'(fwd_sel), 32'h0);
    set_id(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd31, 5'd0, 5'd10, 1'b0, 1'b0);
    chk("null_ld_nostall", 32'(stall), 32'd0);
    idle();

    // Younger ALU writer masks older load
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 5'd10, 1'b0, 1'b0);
    chk("mask_nostall", 32'(stall), 32'd0);
    tick();
    chk("mask_fwd1", 32'(fwd_sel), 32'h1);
    idle();

    // Flush on the stall cycle: bubble, counter unchanged
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd6, 5'd0, 5'd10, 1'b0, 1'b0);
    chk("fl_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("fl_bubble", 32'(ex_valid), 32'd0);
    chk("fl_cnt", 32'(stall_cnt), 32'd1);
    idle();

    // Hold during stall: frozen for 3 cycles
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 5'd10, 1'b0, 1'b0);
    chk("hd_stall", 32'(stall), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hd_stall_frz", 32'(stall), 32'd1);
      chk("hd_cnt_frz", 32'(stall_cnt), 32'd1);
      chk("hd_exv_frz", 32'(ex_valid), 32'd1);
    end
    hold = 1'b0;
    tick();
    chk("hd_cnt2", 32'(stall_cnt), 32'd2);
    chk("hd_bubble", 32'(ex_valid), 32'd0);
    chk("hd_stall_end", 32'(stall), 32'd0);
    tick();
    chk("hd_fwd_s1", 32'(fwd_sel), 32'h8);
    idle();

    // Async reset mid-stall
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd0, 5'd10, 1'b0, 1'b0);
    chk("rs_stall", 32'(stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rs_stall0", 32'(stall), 32'd0);
    chk("rs_exv0", 32'(ex_valid), 32'd0);
    chk("rs_fwd0", 32'(fwd_sel), 32'h0);
    chk("rs_cnt0", 32'(stall_cnt), 32'd0);
    #2 rst = 1'b0;
    tick();
    chk("rs_post_exv", 32'(ex_valid), 32'd1);
    chk("rs_post_fwd", 32'(fwd_sel), 32'h0);
    chk("rs_post_cnt", 32'(stall_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
